// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event arbiter.
package btn_evt_pkg;

  typedef enum logic [0:0] {IDLE, OFFER} arb_state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_BTN     = 16;

  // First set bit of pend searching upward from ptr, wrapping at n (n <= MAX_BTN).
  function automatic int unsigned rr_pick(input logic [MAX_BTN-1:0] pend,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned pick;
    logic [4:0]  idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_BTN; k++) begin
      idx = 5'(ptr + k);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if (k < n && !found && pend[idx[3:0]]) begin
        pick  = 32'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// Per-button front end: 2-flop synchroniser, optional debounce filter
// (enabled by BTN_DEBOUNCE_EN) and rising-edge detector.
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic edge_o
);

  localparam int unsigned SettleW = $clog2(SYNC_STAGES + 1);

  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 65535) begin : g_cfg_err
    $error("btn_channel: DEBOUNCE_CYCLES must be in 1..65535");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SettleW-1:0]     settle_q, settle_d;
  logic                   armed_q, armed_d;
  logic                   lvl_dly_q, lvl_dly_d;
  logic                   sync2, settled, lvl;

  assign sync2   = sync_q[SYNC_STAGES-1];
  assign settled = (settle_q == SettleW'(SYNC_STAGES));

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2 != filt_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2;
`endif

  // A channel only arms once it has seen a genuinely low input after reset, so a
  // button held through reset does not fire until it is released and pressed again.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_i};
    settle_d  = settled ? settle_q : settle_q + 1'b1;
    armed_d   = armed_q | (settled & ~sync2);
    lvl_dly_d = lvl;
    edge_o    = lvl & ~lvl_dly_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      lvl_dly_q <= lvl_dly_d;
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button edge collector with round-robin valid/ready event port.
// Optional debounce filter per channel is enabled by defining BTN_DEBOUNCE_EN.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ID_W            = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] pending,
  output logic             overflow
);

  if (N_BTN < 2 || N_BTN > MAX_BTN) begin : g_cfg_err
    $error("btn_event_arbiter: N_BTN must be in 2..16");
  end

  logic [N_BTN-1:0] edge_w, clr_vec;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  arb_state_t       state_q, state_d;
  logic             accept;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_in[i]),
      .edge_o(edge_w[i])
    );
  end

  // Set beats clear when an edge lands in the same cycle as its accept.
  always_comb begin
    accept  = evt_valid_q & evt_ready;
    clr_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr_vec[i] = accept & (evt_id_q == ID_W'(i));
    end
    pending_d  = edge_w | (pending_q & ~clr_vec);
    overflow_d = overflow_q | (|(edge_w & pending_q & ~clr_vec));
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          evt_id_d    = ID_W'(rr_pick(MAX_BTN'(pending_q), 32'(rr_ptr_q), N_BTN));
          evt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = (evt_id_q == ID_W'(N_BTN - 1)) ? '0 : evt_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_btn_event_arbiter;

  localparam int N = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic         evt_ready;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ev_q[$];

  btn_event_arbiter #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model, stepped on each rising edge from the sampled inputs.
  logic [N-1:0] hist[$];
  bit           m_on = 1'b0;
  bit           m_valid;
  int           m_id, m_ptr;
  logic [N-1:0] m_pend;
  bit           m_ovf;
  bit           seen_low[N];
  bit           flt[N];
  bit           flt_prev[N];

  function automatic bit smp(input int i, input int j);
    if (j < 1 || j > hist.size()) return 1'b0;
    return hist[j-1][i];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      m_on = 1'b1; m_valid = 1'b0; m_id = 0; m_ptr = 0; m_pend = '0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        seen_low[i] = 1'b0; flt[i] = 1'b0; flt_prev[i] = 1'b0;
      end
    end else if (m_on) begin
      int           n;
      bit           acc, lv, lvp, e, clr, flip;
      logic [N-1:0] np;
      hist.push_back(btn_in);
      n   = hist.size();
      acc = m_valid && evt_ready;
      np  = m_pend;
      for (int i = 0; i < N; i++) begin
        if (n - 3 >= 1 && !smp(i, n - 3)) seen_low[i] = 1'b1;
        if (DB == 0) begin
          lv  = smp(i, n - 2);
          lvp = smp(i, n - 3);
        end else begin
          lv   = flt[i];
          lvp  = flt_prev[i];
          flip = 1'b1;
          for (int j = 0; j < DB; j++) if (smp(i, n - 2 - j) == flt[i]) flip = 1'b0;
          flt_prev[i] = flt[i];
          if (flip) flt[i] = !flt[i];
        end
        e   = lv && !lvp && seen_low[i];
        clr = acc && (m_id == i);
        if (e && m_pend[i] && !clr) m_ovf = 1'b1;
        np[i] = e | (m_pend[i] & !clr);
      end
      if (!m_valid) begin
        if (m_pend != '0) begin
          for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
          m_valid = 1'b1;
        end
      end else if (evt_ready) begin
        m_valid = 1'b0;
        m_ptr   = (m_id + 1) % N;
      end
      m_pend = np;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_evt_valid", 32'(evt_valid), 32'(m_valid));
      if (m_valid) chk("model_evt_id", 32'(evt_id), m_id);
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      if (!reset && evt_valid && evt_ready) ev_q.push_back(int'(evt_id));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] b);
    reset = 1'b1; btn_in = b; evt_ready = 1'b0;
    step(2);
    reset = 1'b0;
    ev_q.delete();
  endtask

  int first;

  initial begin
    reset = 1'b1; btn_in = '0; evt_ready = 1'b0;

    // Buttons held through reset stay silent until released and pressed again.
    do_reset(4'b1111);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(12 + DB);
    chk("held_pending", 32'(pending), 0);
    chk("held_events", ev_q.size(), 0);
    btn_in = '0;
    step(8 + DB);
    btn_in = 4'b0001;
    step(12 + DB);
    chk("repress_events", ev_q.size(), 1);
    chk("repress_id", (ev_q.size() > 0) ? ev_q[0] : 99, 0);

    // Single press on channel 2 with the consumer ready.
    do_reset('0);
    evt_ready = 1'b1;
    step(4);
    btn_in = 4'b0100;
    step(2 + DB);
    chk("single_pend_early", 32'(pending), 0);
    step(1);
    chk("single_pend", 32'(pending), 4'b0100);
    chk("single_valid_early", 32'(evt_valid), 0);
    step(1);
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_id", 32'(evt_id), 2);
    step(1);
    chk("single_valid_drop", 32'(evt_valid), 0);
    chk("single_pend_clr", 32'(pending), 0);
    chk("single_rr_ptr", 32'(dut.rr_ptr_q), 3);

    // Simultaneous presses served 0,1,3 with a mandatory idle gap between offers.
    do_reset('0);
    evt_ready = 1'b1;
    step(4);
    btn_in = 4'b1011;
    step(3 + DB);
    chk("simul_pend", 32'(pending), 4'b1011);
    for (int j = 0; j < 6; j++) begin
      step(1);
      chk("simul_alternate", 32'(evt_valid), (j % 2 == 0) ? 1 : 0);
    end
    step(2);
    chk("simul_count", ev_q.size(), 3);
    chk("simul_ord0", (ev_q.size() > 0) ? ev_q[0] : 99, 0);
    chk("simul_ord1", (ev_q.size() > 1) ? ev_q[1] : 99, 1);
    chk("simul_ord2", (ev_q.size() > 2) ? ev_q[2] : 99, 3);

    // Backpressure holds the offer; a second press while pending is an overflow.
    do_reset('0);
    step(4);
    btn_in = 4'b0010;
    step(4 + DB);
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_id", 32'(evt_id), 1);
    for (int j = 0; j < 20; j++) begin
      step(1);
      chk("bp_hold_valid", 32'(evt_valid), 1);
      chk("bp_hold_id", 32'(evt_id), 1);
    end
    btn_in = '0;
    step(8 + DB);
    btn_in = 4'b0010;
    step(4 + DB);
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_pend", 32'(pending), 4'b0010);
    evt_ready = 1'b1;
    step(1);
    chk("bp_accept_valid", 32'(evt_valid), 0);
    chk("bp_accept_pend", 32'(pending), 0);
    chk("bp_ovf_sticky", 32'(overflow), 1);
    evt_ready = 1'b0;
    step(3);
    chk("bp_ovf_sticky2", 32'(overflow), 1);

`ifndef BTN_DEBOUNCE_EN
    // Re-press edge lands in the same cycle as the accept: set wins, no overflow.
    do_reset('0);
    step(4);
    btn_in = 4'b0010;
    step(1);
    btn_in = 4'b0000;
    step(1);
    btn_in = 4'b0010;
    step(2);
    chk("race_valid", 32'(evt_valid), 1);
    chk("race_id", 32'(evt_id), 1);
    evt_ready = 1'b1;
    step(1);
    chk("race_pend", 32'(pending), 4'b0010);
    chk("race_ovf", 32'(overflow), 0);
    chk("race_gap", 32'(evt_valid), 0);
    step(1);
    chk("race_valid2", 32'(evt_valid), 1);
    chk("race_id2", 32'(evt_id), 1);
    step(1);
    chk("race_pend_clr", 32'(pending), 0);
    chk("race_ovf_final", 32'(overflow), 0);
`endif

    // Short and long pulses; the filter swallows pulses shorter than its window.
    do_reset('0);
    evt_ready = 1'b1;
    step(4);
    btn_in = 4'b0001;
    step(3);
    btn_in = '0;
    step(12 + DB);
    chk("pulse3_events", ev_q.size(), (DB == 0) ? 1 : 0);
    ev_q.delete();
    btn_in = 4'b1000;
    first  = -1;
    for (int t = 1; t <= 20; t++) begin
      step(1);
      if (t == 5) btn_in = '0;
      if (evt_valid && first < 0) first = t - 1;
    end
    chk("pulse5_latency", first, 3 + DB);
    chk("pulse5_events", ev_q.size(), 1);
    chk("pulse5_id", (ev_q.size() > 0) ? ev_q[0] : 99, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
